// File: rtl/lsu_mem_stage_pkg.sv
// Shared LSU types: funct3 encodings, MEMORY-stage FSM states, legality helpers.
// Pure declarations; no timing or backpressure of its own.
package lsu_mem_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    LF_LB  = 3'b000,
    LF_LH  = 3'b001,
    LF_LW  = 3'b010,
    LF_LBU = 3'b100,
    LF_LHU = 3'b101
  } load_fun3_t;

  typedef enum logic [2:0] {
    SF_SB = 3'b000,
    SF_SH = 3'b001,
    SF_SW = 3'b010
  } store_fun3_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_R,
    LSU_RESP
  } lsu_state_t;

  function automatic logic fun3_legal(input logic is_store, input logic [2:0] f);
    if (is_store) return (f < 3'b011);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
           (f == 3'b100) || (f == 3'b101);
  endfunction

  // funct3[1:0] encodes access size for both loads and stores: 0=byte, 1=half, 2=word.
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] o);
    return ((f[1:0] == 2'b01) && o[0]) || ((f[1:0] == 2'b10) && (o != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed lane of a raw word and sign/zero-extends it.
// Purely combinational, zero latency; no flow control.
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]            fun3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'b00:   byte_lane = raw[7:0];
      2'b01:   byte_lane = raw[15:8];
      2'b10:   byte_lane = raw[23:16];
      default: byte_lane = raw[31:24];
    endcase
    half_lane = offset[1] ? raw[31:16] : raw[15:0];

    data = '0;
    case (fun3)
      LF_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      LF_LBU:  data = {24'h000000, byte_lane};
      LF_LH:   data = {{16{half_lane[15]}}, half_lane};
      LF_LHU:  data = {16'h0000, half_lane};
      LF_LW:   data = raw;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEMORY-stage load/store unit; LSU_MISALIGN_TRAP_EN makes misaligned ops error instead of masking.
// Latency: store resp 2 cycles after accept, load 3 (plus gnt/rvalid stalls); errors resp 1 cycle after accept.
// Backpressure: req_ready only in IDLE; mem_req and its fields hold until mem_gnt.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_fun3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state;
  logic [2:0]            ld_fun3;
  logic [1:0]            ld_off;
  logic [1:0]            off;
  logic [1:0]            eff_off;
  logic                  bad;
  logic [3:0]            wstrb_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    off = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    bad = !fun3_legal(req_is_store, req_fun3) || misaligned(req_fun3, off);
`else
    bad = !fun3_legal(req_is_store, req_fun3);
`endif
    // Forcing natural alignment is a no-op for legal aligned ops and for the trap build.
    eff_off = off;
    case (req_fun3[1:0])
      2'b01:   eff_off = {off[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = off;
    endcase

    wstrb_n = 4'b0000;
    wdata_n = '0;
    if (req_is_store) begin
      case (req_fun3[1:0])
        2'b00: begin
          wstrb_n = 4'b0001 << eff_off;
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_n = 4'b0011 << eff_off;
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          wstrb_n = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  lsu_load_align u_align (
    .fun3   (ld_fun3),
    .offset (ld_off),
    .raw    (mem_rdata),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LSU_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
      ld_fun3    <= 3'b000;
      ld_off     <= 2'b00;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            mem_we     <= req_is_store;
            mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb  <= wstrb_n;
            mem_wdata  <= wdata_n;
            ld_fun3    <= req_fun3;
            ld_off     <= eff_off;
            resp_rdata <= '0;
            resp_err   <= bad;
            if (bad) begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
            end else begin
              state   <= LSU_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= LSU_WAIT_R;
            end
          end
        end
        LSU_WAIT_R: begin
          if (mem_rvalid) begin
            resp_rdata <= ld_data;
            resp_valid <= 1'b1;
            state      <= LSU_RESP;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: hand-computed vectors, latency and stall checks, reset abort.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_fun3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_chk  = 0;
  int n_pass = 0;

  int          r_lat;
  logic        r_saw_req, r_stable, r_we, r_once, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_strb;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_fun3     (req_fun3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Issues one op, plays the memory side with gdly stall cycles before gnt and rdly
  // extra cycles before rvalid. r_lat is the edge (counted from accept) at which the
  // consumer captures resp_valid; 0 means it never came.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int gdly, input int rdly);
    int   n, req_cyc, wcnt;
    logic granted, done;
    n = 0; req_cyc = 0; wcnt = 0; granted = 1'b0; done = 1'b0;
    r_lat = 0; r_saw_req = 1'b0; r_stable = 1'b1; r_once = 1'b0;
    r_addr = '0; r_strb = '0; r_wdata = '0; r_we = 1'b0; r_rdata = '0; r_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_fun3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    while (n < 60) begin
      @(negedge clk);
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (resp_valid) begin
        r_lat = n + 1; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
      if (mem_req) begin
        if (!r_saw_req) begin
          r_saw_req = 1'b1;
          r_addr = mem_addr; r_strb = mem_wstrb; r_wdata = mem_wdata; r_we = mem_we;
        end else if (mem_addr !== r_addr || mem_wstrb !== r_strb ||
                     mem_wdata !== r_wdata || mem_we !== r_we) begin
          r_stable = 1'b0;
        end
        req_cyc++;
        if (req_cyc > gdly) begin
          mem_gnt = 1'b1; granted = 1'b1;
        end
      end else if (granted && !st && !done) begin
        if (wcnt == rdly) begin
          mem_rvalid = 1'b1; mem_rdata = word; done = 1'b1;
        end
        wcnt++;
      end
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    r_once = !resp_valid && req_ready;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_fun3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    rst = 1'b0;

    // SW, gnt in first REQ cycle
    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    chk("sw_addr", r_addr, 32'h100);
    chk("sw_strb", r_strb, 4'b1111);
    chk("sw_wdata", r_wdata, 32'hDEADBEEF);
    chk("sw_we", r_we, 1);
    chk("sw_lat", r_lat, 2);
    chk("sw_err", r_err, 0);
    chk("sw_rdata", r_rdata, 0);
    chk("sw_once", r_once, 1);

    run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    chk("sb_addr", r_addr, 32'h100);
    chk("sb_strb", r_strb, 4'b1000);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);

    run_op(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 0, 0);
    chk("sh_strb", r_strb, 4'b1100);
    chk("sh_wdata", r_wdata, 32'h12341234);

    run_op(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 0);
    chk("lb_data", r_rdata, 32'hFFFFFF80);
    chk("lb_lat", r_lat, 3);
    chk("lb_we", r_we, 0);
    run_op(1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0, 0);
    chk("lbu_data", r_rdata, 32'h00000080);
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 0);
    chk("lh_data", r_rdata, 32'hFFFF8001);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 0);
    chk("lhu_data", r_rdata, 32'h00008001);

    // LW with gnt stalled 3 cycles and rvalid 2 further cycles late
    run_op(1'b0, 3'b010, 32'h2C4, 32'h0, 32'hCAFEF00D, 3, 2);
    chk("lw_stall_lat", r_lat, 8);
    chk("lw_stall_stable", r_stable, 1);
    chk("lw_stall_addr", r_addr, 32'h2C4);
    chk("lw_stall_data", r_rdata, 32'hCAFEF00D);
    chk("lw_stall_once", r_once, 1);

    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_req", r_saw_req, 0);
    chk("lw_mis_err", r_err, 1);
    chk("lw_mis_data", r_rdata, 0);
    chk("lw_mis_lat", r_lat, 1);
`else
    chk("lw_mis_req", r_saw_req, 1);
    chk("lw_mis_addr", r_addr, 32'h100);
    chk("lw_mis_err", r_err, 0);
    chk("lw_mis_data", r_rdata, 32'h12345678);
`endif

    run_op(1'b0, 3'b111, 32'h100, 32'h0, 32'h55555555, 0, 0);
    chk("ill_ld_req", r_saw_req, 0);
    chk("ill_ld_err", r_err, 1);
    chk("ill_ld_data", r_rdata, 0);
    chk("ill_ld_lat", r_lat, 1);
    run_op(1'b1, 3'b011, 32'h100, 32'h1, 32'h0, 0, 0);
    chk("ill_st_req", r_saw_req, 0);
    chk("ill_st_err", r_err, 1);

    // Reset while waiting for read data; the late rvalid must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_fun3 = 3'b010; req_addr = 32'h200;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_op_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_op_wait", mem_req, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    chk("rst_op_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_op_ready_after", req_ready, 1);
    chk("rst_op_no_resp", resp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_op_no_resp2", resp_valid, 0);
    chk("rst_op_rdata", resp_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
